unit_adder_arbiter: RTL and testbench

//  Round-robin scheduler sharing one unit_adder (2-cycle registered adder) among NUM_REQ requesters.

---
 rtl/unit_adder_arbiter.sv | 179 +++++++++++++++++
 tb/tb_unit_adder_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unit_adder_arbiter.sv
// unit_adder_arbiter
//   Round-robin scheduler that shares one registered adder (ADD_LATENCY
//   clocks from operand sample to visible sum) among NUM_REQ requesters.
//   Each op travels as a {valid,id} tag down a pipe that is aligned to the
//   adder latency. Results land in a response FIFO together with the id of
//   the requester that issued them. New ops are issued only when a FIFO slot
//   is already reserved for them, so the FIFO can never overflow.
//
// Handshakes (both sides): a beat transfers on a rising clk edge where
//   valid && ready. The producer holds valid and its data stable until
//   that edge. ready may depend combinationally on valid.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   req_valid/req_ready     per-requester operand handshake (ready one-hot or 0)
//   req_a, req_b            flattened operands, slice i belongs to requester i
//   add_rst_p               adder reset (active high)
//   add_a, add_b            operands to the shared adder
//   add_sum, add_carry      adder result, ADD_LATENCY clocks after sampling
//   rsp_valid/rsp_ready     response handshake, FIFO head
//   rsp_id/rsp_sum/rsp_carry response payload
//   busy                    op in flight or FIFO not empty
//   err_overflow            sticky: FIFO push while full
module unit_adder_arbiter #(
    parameter int DATA_WIDTH  = 4,
    parameter int NUM_REQ     = 4,
    parameter int ADD_LATENCY = 2,
    parameter int RSP_DEPTH   = 4,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic                          add_rst_p,
    output logic [DATA_WIDTH-1:0]         add_a,
    output logic [DATA_WIDTH-1:0]         add_b,
    input  logic [DATA_WIDTH-1:0]         add_sum,
    input  logic                          add_carry,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_sum,
    output logic                          rsp_carry,
    output logic                          busy,
    output logic                          err_overflow
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int ENT_W = ID_W + DATA_WIDTH + 1;

    // Tag pipe: one {valid,id} per adder stage.
    logic [ADD_LATENCY-1:0] tag_v;
    logic [ID_W-1:0]        tag_id [ADD_LATENCY];

    logic [ID_W-1:0]        last_grant;

    logic [ENT_W-1:0]       fifo_mem [RSP_DEPTH];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [CNT_W-1:0]       fifo_count;
    logic                   err_q;

    logic [OCC_W-1:0]       occupancy;
    logic                   issue_ok;
    logic                   grant_found;
    logic [ID_W-1:0]        grant_id;
    logic                   transfer;
    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic                   push_ok;

    // Credit: every op in the tag pipe already owns a FIFO slot. A pop in
    // the same cycle is deliberately not counted, keeping the path short.
    always_comb begin
        occupancy = OCC_W'(fifo_count);
        for (int k = 0; k < ADD_LATENCY; k++) begin
            occupancy = occupancy + OCC_W'(tag_v[k]);
        end
    end

    assign issue_ok = occupancy < OCC_W'(RSP_DEPTH);

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        if (issue_ok) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = (int'(last_grant) + k) % NUM_REQ;
                if (!grant_found && req_valid[idx]) begin
                    grant_found = 1'b1;
                    grant_id    = ID_W'(idx);
                end
            end
        end
    end

    // A grant only goes to a requester with valid set, so grant == transfer.
    assign transfer  = rst_n && grant_found;
    assign req_ready = transfer ? (NUM_REQ'(1) << grant_id) : '0;
    assign add_a     = transfer ? req_a[grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign add_b     = transfer ? req_b[grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign add_rst_p = ~rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= ID_W'(NUM_REQ - 1);
        end else if (transfer) begin
            last_grant <= grant_id;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_v <= '0;
            for (int k = 0; k < ADD_LATENCY; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            tag_v[0]  <= transfer;
            tag_id[0] <= grant_id;
            for (int k = 1; k < ADD_LATENCY; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

    // The last tag stage lines up with the adder output.
    assign push      = tag_v[ADD_LATENCY-1];
    assign rsp_valid = rst_n && (fifo_count != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign fifo_full = fifo_count == CNT_W'(RSP_DEPTH);
    // When full, a same-cycle pop frees the head slot, which wr_ptr equals.
    assign push_ok   = push && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= {tag_id[ADD_LATENCY-1], add_sum, add_carry};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            err_q      <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= (wr_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (!push_ok && pop) begin
                fifo_count <= fifo_count - 1'b1;
            end
            if (push && fifo_full && !pop) begin
                err_q <= 1'b1;
            end
        end
    end

    assign {rsp_id, rsp_sum, rsp_carry} = fifo_mem[rd_ptr];
    assign busy         = rst_n && ((|tag_v) || (fifo_count != '0));
    assign err_overflow = err_q;

endmodule

// File: tb/tb_unit_adder_arbiter.sv
module tb_unit_adder_arbiter;

  localparam int DW    = 4;
  localparam int NR    = 4;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int IDW   = $clog2(NR);
  localparam int EW    = IDW + DW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*DW-1:0] req_a;
  logic [NR*DW-1:0] req_b;
  logic             add_rst_p;
  logic [DW-1:0]    add_a;
  logic [DW-1:0]    add_b;
  logic [DW-1:0]    add_sum;
  logic             add_carry;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [IDW-1:0]   rsp_id;
  logic [DW-1:0]    rsp_sum;
  logic             rsp_carry;
  logic             busy;
  logic             err_overflow;

  unit_adder_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .ADD_LATENCY(LAT),
    .RSP_DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .add_rst_p   (add_rst_p),
    .add_a       (add_a),
    .add_b       (add_b),
    .add_sum     (add_sum),
    .add_carry   (add_carry),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_sum     (rsp_sum),
    .rsp_carry   (rsp_carry),
    .busy        (busy),
    .err_overflow(err_overflow)
  );

  // Two-stage registered adder attached to the scheduler.
  logic [DW:0] add_s1, add_s2;
  always @(posedge clk) begin
    if (add_rst_p) begin
      add_s1 <= '0;
      add_s2 <= '0;
    end else begin
      add_s1 <= {1'b0, add_a} + {1'b0, add_b};
      add_s2 <= add_s1;
    end
  end
  assign add_sum   = add_s2[DW-1:0];
  assign add_carry = add_s2[DW];

  // ---------------- requester state ----------------
  logic [NR-1:0] va;
  logic [DW-1:0] a_op [NR];
  logic [DW-1:0] b_op [NR];
  logic [NR-1:0] taken;

  assign req_valid = va;
  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NR; i++) begin
      req_a[i*DW +: DW] = a_op[i];
      req_b[i*DW +: DW] = b_op[i];
    end
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q [$];
  int            exp_cyc_q [$];
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;
  int            m_out = 0;
  int            m_last = NR - 1;
  int            m_id;
  int            m_j;
  int            m_s;
  logic [NR-1:0] m_grant;
  logic          exp_v;
  logic [EW-1:0] exp_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: ops outstanding = accepted but not yet consumed; a new
  // op may be accepted only while fewer than DEPTH are outstanding.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_add_rst_p", 32'(add_rst_p), 1);
      chk("rst_add_a", 32'(add_a), 0);
      chk("rst_err", 32'(err_overflow), 0);
      exp_q.delete();
      exp_cyc_q.delete();
      m_out  = 0;
      m_last = NR - 1;
    end else begin
      m_grant = '0;
      m_id    = 0;
      if (m_out < DEPTH) begin
        for (int k = 1; k <= NR; k++) begin
          m_j = (m_last + k) % NR;
          if (m_grant == '0 && va[m_j]) begin
            m_grant[m_j] = 1'b1;
            m_id = m_j;
          end
        end
      end
      chk("req_ready", 32'(req_ready), 32'(m_grant));
      chk("busy", 32'(busy), 32'(m_out != 0));
      chk("err_overflow", 32'(err_overflow), 0);
      chk("add_rst_p", 32'(add_rst_p), 0);
      if (m_grant != '0) begin
        m_s = int'(a_op[m_id]) + int'(b_op[m_id]);
        exp_q.push_back({IDW'(m_id), DW'(m_s % (1 << DW)), 1'(m_s / (1 << DW))});
        exp_cyc_q.push_back(cyc);
        m_out++;
        m_last = m_id;
      end
      if (rsp_valid && rsp_ready) m_out--;
    end
  end

  // Monitor: response presence timing and payload.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_v = (exp_q.size() > 0) && (exp_cyc_q[0] + LAT + 1 <= cyc);
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_extra: got id=%0d sum=%0h carry=%0d with nothing expected (cycle %0d)",
                   rsp_id, rsp_sum, rsp_carry, cyc);
        end else begin
          exp_e = exp_q.pop_front();
          void'(exp_cyc_q.pop_front());
          chk("rsp_payload", 32'({rsp_id, rsp_sum, rsp_carry}), 32'(exp_e));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    taken = req_valid & req_ready;
    @(posedge clk);
    #1;
    va = va & ~taken;
  endtask

  task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    va[i]   = 1'b1;
    a_op[i] = a;
    b_op[i] = b;
  endtask

  task automatic refill_all();
    for (int i = 0; i < NR; i++) begin
      if (!va[i]) set_op(i, DW'($urandom_range(0, (1 << DW) - 1)), DW'($urandom_range(0, (1 << DW) - 1)));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    va = '0;
    rsp_ready = 1'b1;
    while ((busy || exp_q.size() != 0) && n < 64) begin
      tick();
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 0);
    chk("drain_busy", 32'(busy), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    va        = '1;
    for (int i = 0; i < NR; i++) begin
      a_op[i] = DW'(i);
      b_op[i] = DW'(i + 1);
    end

    // Reset held with every requester asking.
    repeat (3) tick();
    va    = '0;
    rst_n = 1'b1;
    tick();

    // Single ops, with and without carry.
    set_op(0, 4'h9, 4'h8);
    repeat (5) tick();
    set_op(0, 4'h3, 4'h4);
    repeat (5) tick();
    set_op(2, 4'hF, 4'hF);
    repeat (5) tick();
    drain();

    // Fairness: everyone valid for 8 cycles.
    refill_all();
    repeat (8) begin
      tick();
      refill_all();
    end
    drain();

    // Backpressure: consumer stalled, then released.
    rsp_ready = 1'b0;
    refill_all();
    repeat (8) begin
      tick();
      refill_all();
    end
    rsp_ready = 1'b1;
    repeat (8) begin
      tick();
      refill_all();
    end
    drain();

    // Reset with two ops in the adder and one buffered.
    rsp_ready = 1'b0;
    refill_all();
    repeat (3) begin
      tick();
      refill_all();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    refill_all();
    rsp_ready = 1'b1;
    repeat (4) begin
      tick();
      refill_all();
    end
    drain();

    // Random traffic.
    repeat (10000) begin
      rsp_ready = ($urandom_range(0, 99) < 70);
      for (int i = 0; i < NR; i++) begin
        if (!va[i] && $urandom_range(0, 99) < 50)
          set_op(i, DW'($urandom_range(0, (1 << DW) - 1)), DW'($urandom_range(0, (1 << DW) - 1)));
      end
      tick();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
